// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide unit with pipeline stall
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      ALU_Selection,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10011;
  localparam logic [4:0] OP_MULHU  = 5'b10100;
  localparam logic [4:0] OP_DIV    = 5'b10101;
  localparam logic [4:0] OP_DIVU   = 5'b10110;
  localparam logic [4:0] OP_REM    = 5'b10111;
  localparam logic [4:0] OP_REMU   = 5'b11000;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   counter;
  logic [4:0]      op;
  logic            neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] acc, lo;
  logic            accept;

  // Incoming operation decode: validity, operand signedness, special cases
  logic            code_valid, in_div, in_mul, sa, sb, special;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] in_mag_a, in_mag_b, special_val;

  always_comb begin
    code_valid  = ALU_Selection inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                        OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    in_div      = ALU_Selection inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    in_mul      = code_valid && !in_div;
    sa          = ALU_Selection inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sb          = ALU_Selection inside {OP_MULH, OP_DIV, OP_REM};
    a_neg       = sa && A[XLEN-1];
    b_neg       = sb && B[XLEN-1];
    in_mag_a    = a_neg ? -A : A;
    in_mag_b    = b_neg ? -B : B;
    special     = 1'b0;
    special_val = '0;
    if (in_div && B == '0) begin
      special     = 1'b1;
      special_val = (ALU_Selection inside {OP_DIV, OP_DIVU}) ? '1 : A;
    end else if ((ALU_Selection inside {OP_DIV, OP_REM}) && A == INT_MIN && B == '1) begin
      special     = 1'b1;
      special_val = (ALU_Selection == OP_DIV) ? INT_MIN : '0;
    end
  end

  // One shift-add (multiply) or restoring-subtract (divide) step plus final sign fix
  logic            op_is_mul;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] acc_nx, lo_nx, final_val;
  logic [2*XLEN-1:0] product, product_fix;

  always_comb begin
    op_is_mul = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
    div_shift = {acc, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (op_is_mul) begin
      acc_nx = mul_sum[XLEN:1];
      lo_nx  = {mul_sum[0], lo[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_nx = div_diff[XLEN-1:0];
      lo_nx  = {lo[XLEN-2:0], 1'b1};
    end else begin
      acc_nx = div_shift[XLEN-1:0];
      lo_nx  = {lo[XLEN-2:0], 1'b0};
    end
    product     = {acc_nx, lo_nx};
    product_fix = neg ? -product : product;
    case (op)
      OP_MUL:                     final_val = product_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_val = product_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            final_val = neg ? -lo_nx : lo_nx;
      default:                    final_val = neg ? -acc_nx : acc_nx;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && code_valid && !flush) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush)                state_next = IDLE;
        else if (counter == LAST) state_next = DONE;
      end
      DONE: begin
        result_valid = !flush;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration registers and the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      op      <= '0;
      neg     <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      lo      <= '0;
      result  <= '0;
    end else if (accept) begin
      counter <= '0;
      op      <= ALU_Selection;
      neg     <= (ALU_Selection inside {OP_REM}) ? a_neg : (a_neg ^ b_neg);
      mag_a   <= in_mag_a;
      mag_b   <= in_mag_b;
      acc     <= '0;
      lo      <= in_mul ? in_mag_b : in_mag_a;
      if (special) result <= special_val;
    end else if (state == CALC && !flush) begin
      acc     <= acc_nx;
      lo      <= lo_nx;
      counter <= counter + 1'b1;
      if (counter == LAST) result <= final_val;
    end else begin
      counter <= '0;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  localparam int XLEN = 32;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10011;
  localparam logic [4:0] OP_MULHU  = 5'b10100;
  localparam logic [4:0] OP_DIV    = 5'b10101;
  localparam logic [4:0] OP_DIVU   = 5'b10110;
  localparam logic [4:0] OP_REM    = 5'b10111;
  localparam logic [4:0] OP_REMU   = 5'b11000;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  sel;
  logic [31:0] a, b;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .ALU_Selection(sel),
    .A(a), .B(b), .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_code(input logic [4:0] s);
    return s inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic bit is_special(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y);
    if ((s inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && y == 32'd0) return 1'b1;
    if ((s inside {OP_DIV, OP_REM}) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    case (s)
      OP_MUL:    begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(x) / $signed(y);
      end
      OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return $signed(x) % $signed(y);
      end
      OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REMU: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Transaction-level model: cycles remaining until the result, done flag, held result
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_known = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pending = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_result = 32'd0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_done = 1'b1; m_result = m_pending; end
        end
      end else if (start && valid_code(sel) && !flush) begin
        m_pending = model(sel, a, b);
        if (is_special(sel, a, b)) begin m_done = 1'b1; m_result = m_pending; end
        else m_left = XLEN;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_known) begin
      bit e_busy, e_valid, e_stall;
      e_busy  = (m_left > 0) || m_done;
      e_valid = m_done && !flush;
      e_stall = (m_left > 0) || (!e_busy && start && valid_code(sel) && !flush);
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("result_valid", {31'd0, result_valid}, {31'd0, e_valid});
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("result", result, m_result);
    end
  end

  // Issue one op at the current (idle) cycle, measure latency, return in the next idle cycle
  task automatic run_op(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat);
    int n;
    chk("model_pin", model(s, x, y), exp);
    start = 1'b1; sel = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    while (!result_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("op_result", result, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; sel = 5'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_result", result, 32'd0);

    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run_op(OP_DIVU,   32'd100,        32'd7,         32'd14,        33);
    run_op(OP_REMU,   32'd100,        32'd7,         32'd2,         33);
    run_op(OP_DIVU,   32'd7,          32'd0,         32'hFFFF_FFFF, 1);
    run_op(OP_REMU,   32'd7,          32'd0,         32'd7,         1);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    run_op(OP_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 33);
    run_op(OP_DIV,    32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 33);
    run_op(OP_REM,    32'd20,         32'hFFFF_FFFA, 32'd2,         33);

    // Unassigned codes are ignored
    start = 1'b1; sel = 5'b10010; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    chk("bad_code_busy", {31'd0, busy}, 32'd0);
    sel = 5'b00000;
    @(posedge clk); #1;
    chk("bad_code0_busy", {31'd0, busy}, 32'd0);
    chk("bad_code0_stall", {31'd0, stall}, 32'd0);

    // start together with flush is not accepted
    sel = OP_MUL; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    // Flush mid-multiply at counter 10, then a fresh divide right away
    start = 1'b1; sel = OP_MUL; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_valid", {31'd0, result_valid}, 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Reset during CALC returns everything to reset values
    start = 1'b1; sel = OP_DIVU; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_valid", {31'd0, result_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
